// File: rtl/regwr_pkg.sv
// Shared types and sizing for the register-file write-port arbiter.
package regwr_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REGWR_DW  = 32;
  localparam int unsigned REGWR_AW  = 5;
  localparam int unsigned CLR_CNT_W = $clog2(REG_COUNT);

  typedef enum logic [0:0] {
    ST_ARB = 1'b0,
    ST_CLR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester at or above ptr_i, wrapping modulo NREQ.
module rr_picker #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr_i) + k) % NREQ);
      if (!any_valid_o && valid_i[idx]) begin
        any_valid_o      = 1'b1;
        grant_idx_o      = idx;
        grant_oh_o[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file write port, with a 32-write clear sweep.
// Build option: define REGWR_ZERO_DISCARD_EN to accept but drop writes to register 0.
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned DW   = REGWR_DW,
  parameter  int unsigned AW   = REGWR_AW,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  input  logic               clear_req,
  output logic               clear_busy,
  output logic               rf_we,
  output logic [AW-1:0]      rf_rd,
  output logic [DW-1:0]      rf_din,
  output logic [IW-1:0]      grant_id
);

  state_e                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CLR_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   rf_we_q, rf_we_d;
  logic [AW-1:0]          rf_rd_q, rf_rd_d;
  logic [DW-1:0]          rf_din_q, rf_din_d;
  logic [IW-1:0]          grant_id_q, grant_id_d;
  logic                   clear_busy_q, clear_busy_d;

  logic [NREQ-1:0]        grant_oh;
  logic [IW-1:0]          grant_idx;
  logic                   any_valid;
  logic [AW-1:0]          sel_rd;
  logic [DW-1:0]          sel_data;
  logic                   arb_open;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid_i     (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (grant_oh),
    .grant_idx_o (grant_idx),
    .any_valid_o (any_valid)
  );

  assign sel_rd   = req_rd[32'(grant_idx)*AW +: AW];
  assign sel_data = req_data[32'(grant_idx)*DW +: DW];

  // Grants are only offered in arbitration with no stall, no pending clear and reset released.
  assign arb_open  = (state_q == ST_ARB) && !hold && !clear_req && !rst;
  assign req_ready = arb_open ? grant_oh : '0;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    rf_we_d      = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_din_d     = rf_din_q;
    grant_id_d   = grant_id_q;
    clear_busy_d = clear_busy_q;

    case (state_q)
      ST_ARB: begin
        if (clear_req) begin
          state_d      = ST_CLR;
          cnt_d        = '0;
          clear_busy_d = 1'b1;
        end else if (!hold && any_valid) begin
          rr_ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
          grant_id_d = grant_idx;
`ifdef REGWR_ZERO_DISCARD_EN
          if (sel_rd != '0) begin
            rf_we_d  = 1'b1;
            rf_rd_d  = sel_rd;
            rf_din_d = sel_data;
          end
`else
          rf_we_d  = 1'b1;
          rf_rd_d  = sel_rd;
          rf_din_d = sel_data;
`endif
        end
      end

      ST_CLR: begin
        rf_we_d  = 1'b1;
        rf_rd_d  = AW'(cnt_q);
        rf_din_d = '0;
        cnt_d    = cnt_q + CLR_CNT_W'(1);
        // Leave the sweep on the same edge that issues the last register.
        if (cnt_q == CLR_CNT_W'(REG_COUNT - 1)) begin
          state_d      = ST_ARB;
          clear_busy_d = 1'b0;
        end
      end

      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ARB;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_din_q     <= '0;
      grant_id_q   <= '0;
      clear_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_din_q     <= rf_din_d;
      grant_id_q   <= grant_id_d;
      clear_busy_q <= clear_busy_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_din     = rf_din_q;
  assign grant_id   = grant_id_q;
  assign clear_busy = clear_busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: round-robin, hold, clear sweep, reset abort, rd=0 handling.
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               clear_req;
  logic               clear_busy;
  logic               rf_we;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_din;
  logic [1:0]         grant_id;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_din     (rf_din),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] data);
    req_rd[i*AW +: AW]   = rd;
    req_data[i*DW +: DW] = data;
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] rd,
                             input logic [DW-1:0] data, input logic [1:0] gid);
    check({tag, " we"},  64'(rf_we), 64'(1));
    check({tag, " rd"},  64'(rf_rd), 64'(rd));
    check({tag, " din"}, 64'(rf_din), 64'(data));
    check({tag, " gid"}, 64'(grant_id), 64'(gid));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    req_rd    = '0;
    req_data  = '0;
    hold      = 1'b0;
    clear_req = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, AW'(i + 1), DW'(32'hA1 + i));
    tick();
    tick();
    check("rst ready", 64'(req_ready), 64'(0));
    check("rst we", 64'(rf_we), 64'(0));
    check("rst rd", 64'(rf_rd), 64'(0));
    check("rst din", 64'(rf_din), 64'(0));
    check("rst gid", 64'(grant_id), 64'(0));
    check("rst busy", 64'(clear_busy), 64'(0));
    rst = 1'b0;
    req_valid = 4'h0;
    tick();
    check("idle we", 64'(rf_we), 64'(0));

    // Round robin with all four requesters valid: 0,1,2,3,0
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      check_write("rr", AW'(k % 4 + 1), DW'(32'hA1 + (k % 4)), 2'(k % 4));
    end
    // ptr is now 1; grant req2 to move it to 3
    req_valid = 4'b0100;
    tick();
    check_write("mv", 5'd3, 32'hA3, 2'd2);

    // ptr=3, only req2 valid
    set_req(2, 5'd7, 32'h55);
    #1;
    check("wrap ready", 64'(req_ready), 64'(4'b0100));
    tick();
    check_write("wrap", 5'd7, 32'h55, 2'd2);
    req_valid = 4'hF;
    #1;
    check("ptr3 ready", 64'(req_ready), 64'(4'b1000));
    req_valid = 4'h0;
    tick();
    check("hold-val we", 64'(rf_we), 64'(0));
    check("hold-val rd", 64'(rf_rd), 64'(7));
    check("hold-val din", 64'(rf_din), 64'(32'h55));

    // Move ptr to 0 via req3, then stall with req1 and req3 valid
    req_valid = 4'b1000;
    tick();
    check_write("p0", 5'd4, 32'hA4, 2'd3);
    hold = 1'b1;
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold ready", 64'(req_ready), 64'(0));
      tick();
      check("hold we", 64'(rf_we), 64'(0));
    end
    hold = 1'b0;
    #1;
    check("unhold ready", 64'(req_ready), 64'(4'b0010));
    tick();
    check_write("unhold", 5'd2, 32'hA2, 2'd1);
    #1;
    check("unhold next", 64'(req_ready), 64'(4'b1000));
    req_valid = 4'h0;
    tick();

    // Clear sweep with req0 pending
    set_req(0, 5'd9, 32'h99);
    req_valid = 4'b0001;
    clear_req = 1'b1;
    #1;
    check("clr req ready", 64'(req_ready), 64'(0));
    tick();
    clear_req = 1'b0;
    check("clr start busy", 64'(clear_busy), 64'(1));
    check("clr start we", 64'(rf_we), 64'(0));
    for (int c = 0; c < 32; c++) begin
      check("clr ready", 64'(req_ready), 64'(0));
      tick();
      check("clr we", 64'(rf_we), 64'(1));
      check("clr rd", 64'(rf_rd), 64'(c));
      check("clr din", 64'(rf_din), 64'(0));
      check("clr busy", 64'(clear_busy), 64'(c < 31 ? 1 : 0));
    end
    check("post clr ready", 64'(req_ready), 64'(4'b0001));
    tick();
    check_write("post clr", 5'd9, 32'h99, 2'd0);

    // Reset in the middle of a sweep
    req_valid = 4'h0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("abort pre rd", 64'(rf_rd), 64'(9));
    #3;
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    check("abort we", 64'(rf_we), 64'(0));
    check("abort rd", 64'(rf_rd), 64'(0));
    check("abort busy", 64'(clear_busy), 64'(0));
    check("abort ready", 64'(req_ready), 64'(0));
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    tick();
    check("abort after we", 64'(rf_we), 64'(0));
    check("abort after busy", 64'(clear_busy), 64'(0));

    // rd=0 request
    set_req(0, 5'd0, 32'hFF);
    req_valid = 4'b0001;
    #1;
    check("rd0 ready", 64'(req_ready), 64'(4'b0001));
    tick();
`ifdef REGWR_ZERO_DISCARD_EN
    check("rd0 we", 64'(rf_we), 64'(0));
`else
    check_write("rd0", 5'd0, 32'hFF, 2'd0);
`endif
    req_valid = 4'b0011;
    #1;
    check("rd0 ptr ready", 64'(req_ready), 64'(4'b0010));
    req_valid = 4'h0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
